// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 result interface.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned N_WORDS  = 8;
  localparam int unsigned DIGEST_W = WORD_W * N_WORDS;
  localparam int unsigned IDX_W    = $clog2(N_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sha256_digest_tx.sv
// Captures the final digest on done_i and streams it out H0-first as
// N_WORDS words over a valid/ready handshake.
module sha256_digest_tx
  import sha256_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                done_i,
  input  logic [DIGEST_W-1:0] digest_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                overrun
);

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [DIGEST_W-1:0] shadow, shadow_d;
  logic                last_q, last_d;
  logic                overrun_q, overrun_d;
  logic                xfer;
  logic                idx_end;

  assign xfer    = (state == SEND) && out_ready;
  assign idx_end = (idx == IDX_W'(N_WORDS - 1));

  // State register and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      shadow    <= shadow_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: capture, shift-per-transfer, back-to-back reload, overrun
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    shadow_d  = shadow;
    last_d    = last_q;
    overrun_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (done_i) begin
          state_d  = SEND;
          shadow_d = digest_i;
          idx_d    = '0;
          last_d   = (N_WORDS == 1);
        end
      end
      SEND: begin
        if (xfer && idx_end) begin
          idx_d = '0;
          if (done_i) begin
            shadow_d = digest_i;
            last_d   = (N_WORDS == 1);
          end else begin
            state_d  = IDLE;
            shadow_d = '0;
            last_d   = 1'b0;
          end
        end else begin
          if (xfer) begin
            shadow_d = shadow << WORD_W;
            idx_d    = idx + IDX_W'(1);
            last_d   = (idx == IDX_W'(N_WORDS - 2));
          end
          // A new digest can only be accepted on the final transfer
          overrun_d = done_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = shadow[DIGEST_W-1 -: WORD_W];
  assign out_last  = last_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/sha256_digest_tx.md
# sha256_digest_tx

Transmit side of the SHA-256 core's result interface. Captures the 256-bit digest when the hash core pulses completion, then streams it out as eight 32-bit words (H0 first) over a valid/ready handshake. It sits between the hash datapath and the host-facing output bus. It is the unload counterpart of the control/data capture registers that load the core on `start`.

## Interface
- `WORD_W`, 32: output word width.
- `N_WORDS`, 8: words per digest; the digest width is `WORD_W*N_WORDS`.
- `CLK` input 1: single clock, all state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `done_i` input 1: one-cycle pulse; `digest_i` is valid in this cycle.
- `digest_i` input `WORD_W*N_WORDS`: final hash, H0 in bits [255:224], H7 in bits [31:0].
- `out_valid` output 1: `out_data` holds a valid word.
- `out_ready` input 1: the consumer accepts the word this cycle.
- `out_data` output `WORD_W`: current digest word.
- `out_last` output 1: high together with `out_valid` on word index `N_WORDS-1`.
- `busy` output 1: a digest is held and not yet fully sent.
- `overrun` output 1: one-cycle pulse when `done_i` arrives while busy and the digest is dropped.

## Operation
- **States:**
  - IDLE: nothing held.
  - SEND: holding a digest, word index `idx` in 0..`N_WORDS-1`.
- **Handshake:** a transfer occurs in a cycle where `out_valid` and `out_ready` are both 1.
- **IDLE with `done_i`=1:**
  - Capture `digest_i` into a shadow register.
  - Set `idx` to 0 and move to SEND.
- **SEND:**
  - `out_valid` is 1.
  - `out_data` is the shadow word `idx`, counting from the MSB end.
  - `out_last` equals (`idx`==`N_WORDS-1`).
- **Transfer with `idx`<`N_WORDS-1`:** increment `idx`.
- **Transfer with `idx`=`N_WORDS-1`:** return to IDLE and drop `out_valid` next cycle, unless the back-to-back case below applies.
- **Back-to-back:** `done_i` in the same cycle as the last transfer captures the new digest, sets `idx` to 0 and stays in SEND. No overrun is flagged and there is no bubble.
- **`done_i` in SEND with no last transfer that cycle:**
  - The new digest is ignored.
  - `overrun` pulses for one cycle.
  - The held digest and `idx` are unchanged.
- **Stalls:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `idx` hold stable. The block never withdraws `out_valid` before a transfer.
- **`busy`:** equals (state==SEND).
- **Reset (asserted at any time, including mid-stream):**
  - State goes to IDLE; the partial digest is discarded.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `overrun`=0; `idx`=0, shadow register=0.
- **After reset release:** the first `done_i` behaves as in IDLE.

## Timing
- All outputs are registered.
- `done_i` at edge n gives `out_valid`=1 with word H0 after edge n.
- With `out_ready` held at 1, a digest drains in `N_WORDS` consecutive cycles (8), one word per cycle.
- `overrun` is high in the cycle after the offending `done_i`.
- Reset is asynchronous on assertion. Deassertion is synchronised externally; the block requires no specific release alignment.

## Structure
- Shared package `sha256_pkg`:
  - `WORD_W` and `N_WORDS` constants.
  - Digest width constant.
  - State enum: IDLE, SEND.
- The counter `idx` is `$clog2(N_WORDS)` bits wide and does not wrap past `N_WORDS-1`; the last transfer returns it to 0.
- The block is a single module with no sub-module. Word selection is a shift of the shadow register left by `WORD_W` on each transfer, so `out_data` is the shadow register's top word.

## Test plan
- **Basic drain:** reset, then `done_i` with digest = 0x00000000_11111111_…_77777777 and `out_ready`=1.
  - Expect words 0x0, 0x11111111 … 0x77777777 on 8 consecutive cycles.
  - Expect `out_last` only on 0x77777777; `busy` falls after that word.
- **Backpressure:** toggle `out_ready` 1,0,0,1,… during a drain.
  - Each word is held stable across stall cycles.
  - No word is lost or duplicated; 8 transfers total.
- **Overrun:** second `done_i` at word 3 of a drain.
  - `overrun` pulses once.
  - The remaining words 3..7 come from the first digest.
  - `busy` clears after word 7.
- **Back-to-back:** second `done_i` coincides with the last transfer.
  - The next cycle shows H0 of the new digest with `out_valid` staying 1.
  - `overrun` stays 0.
- **Reset mid-stream:** assert `RST`=0 at word 4 with no clock edge in between.
  - `out_valid`, `busy` and `out_data` go to 0 immediately.
  - After release, a new `done_i` streams from word 0.
- **Idle stability:** `out_ready`=1 with no `done_i` for 20 cycles.
  - `out_valid` stays 0 and `overrun` stays 0.
